// File: rtl/lcd_note_writer_pkg.sv
// lcd_note_writer_pkg
//   Shared definitions for the LCD note writer: HD44780 command bytes,
//   the character-word field layout returned by map_rom, and the state
//   encodings of the top sequencer and the byte transmitter.
//   Helper char_byte() maps a 9-bit character word to the byte sent to
//   the LCD.
package lcd_note_writer_pkg;

    // HD44780 commands (8-bit interface)
    localparam logic [7:0] FUNC_SET_8B2L = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
    localparam logic [7:0] DISP_ON       = 8'h0C;  // display on, cursor off, blink off
    localparam logic [7:0] CLEAR         = 8'h01;  // clear display, home cursor
    localparam logic [7:0] ENTRY_INC     = 8'h06;  // increment address, no shift
    localparam logic [7:0] SPACE         = 8'h20;  // blank character

    // Character word: bit 8 marks a printable character, bits 7:0 its code
    localparam int CHAR_VALID_BIT = 8;

    // Top sequencer: one state per LCD byte in flight
    typedef enum logic [3:0] {
        ST_PWRUP    = 4'd0,
        ST_INIT_FS  = 4'd1,
        ST_INIT_ON  = 4'd2,
        ST_INIT_CLR = 4'd3,
        ST_INIT_ENT = 4'd4,
        ST_IDLE     = 4'd5,
        ST_LOOKUP   = 4'd6,
        ST_ADDR_L   = 4'd7,
        ST_CHAR_L   = 4'd8,
        ST_ADDR_R   = 4'd9,
        ST_CHAR_R   = 4'd10
    } top_state_t;

    // Byte transmitter phases
    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_SETUP = 2'd1,
        TX_PULSE = 2'd2,
        TX_WAIT  = 2'd3
    } tx_state_t;

    // A blank cell is written as a space so stale characters are erased.
    function automatic logic [7:0] char_byte(input logic [8:0] word);
        return word[CHAR_VALID_BIT] ? word[7:0] : SPACE;
    endfunction

endpackage

// File: rtl/lcd_byte_tx.sv
// lcd_byte_tx
//   Writes one byte to an HD44780 bus: SETUP (1 cycle, rs/data driven,
//   en low) -> PULSE (EN_HIGH_CYC cycles, en high) -> WAIT (wait_cyc
//   cycles, en low, rs/data held). rs/data hold their last value when idle.
// Ports
//   clk, rst_n      clock, asynchronous active-low reset
//   start           launch a byte; accepted when idle or in the done cycle
//   rs, data        register-select and byte value, captured on accept
//   wait_cyc        post-pulse wait, captured on accept (must be >= 1)
//   busy            a byte is in progress
//   done            1-cycle pulse during the last WAIT cycle
//   lcd_rs/en/data  LCD bus outputs (registered)
import lcd_note_writer_pkg::*;

module lcd_byte_tx #(
    parameter int TW          = 4,
    parameter int EN_HIGH_CYC = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          rs,
    input  logic [7:0]    data,
    input  logic [TW-1:0] wait_cyc,
    output logic          busy,
    output logic          done,
    output logic          lcd_rs,
    output logic          lcd_en,
    output logic [7:0]    lcd_data
);

    localparam logic [TW-1:0] EN_LOAD = TW'(EN_HIGH_CYC - 1);

    tx_state_t     state;
    logic [TW-1:0] cnt;
    logic [TW-1:0] wait_r;

    // done is decoded (not registered) so the sequencer can chain the next
    // byte's SETUP straight after this byte's last WAIT cycle.
    assign done = (state == TX_WAIT) && (cnt == '0);
    assign busy = (state != TX_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= TX_IDLE;
            cnt      <= '0;
            wait_r   <= '0;
            lcd_rs   <= 1'b0;
            lcd_en   <= 1'b0;
            lcd_data <= 8'h00;
        end else if (start && (state == TX_IDLE || done)) begin
            state    <= TX_SETUP;
            lcd_rs   <= rs;
            lcd_data <= data;
            wait_r   <= wait_cyc;
            lcd_en   <= 1'b0;
        end else begin
            case (state)
                TX_SETUP: begin
                    state  <= TX_PULSE;
                    lcd_en <= 1'b1;
                    cnt    <= EN_LOAD;
                end
                TX_PULSE: begin
                    if (cnt == '0) begin
                        state  <= TX_WAIT;
                        lcd_en <= 1'b0;
                        cnt    <= wait_r - 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                TX_WAIT: begin
                    if (cnt == '0) state <= TX_IDLE;
                    else           cnt   <= cnt - 1'b1;
                end
                default: state <= TX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/lcd_note_writer.sv
// lcd_note_writer
//   Accepts a 6-bit note index, looks up its left/right character words in
//   map_rom and writes them to two cells of an HD44780 LCD. Runs the LCD
//   power-up init sequence after every reset.
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   req_valid, req_idx   note request (held by requester until accepted)
//   req_ready            idle and initialised
//   rom_idx              registered index to map_rom
//   rom_left, rom_right  character words from map_rom
//   init_done            sticky high once init completes
//   lcd_rs/rw/en/data    LCD pins (rw tied low, write only)
//
// Handshake: a request is accepted on a rising clk edge where
// req_valid && req_ready. req_ready is high only in IDLE; requests raised
// while busy are not queued, the requester keeps req_valid high until
// accepted, and req_idx must be stable while req_valid is high.
import lcd_note_writer_pkg::*;

module lcd_note_writer #(
    parameter int         EN_HIGH_CYC  = 12,
    parameter int         CMD_WAIT_CYC = 2500,
    parameter int         CLR_WAIT_CYC = 82000,
    parameter int         PWRUP_CYC    = 750000,
    parameter logic [7:0] LEFT_ADDR    = 8'h80,
    parameter logic [7:0] RIGHT_ADDR   = 8'h81
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    input  logic [5:0] req_idx,
    output logic       req_ready,
    output logic [5:0] rom_idx,
    input  logic [8:0] rom_left,
    input  logic [8:0] rom_right,
    output logic       init_done,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_data
);

    localparam int MAX_A = (PWRUP_CYC > CLR_WAIT_CYC) ? PWRUP_CYC : CLR_WAIT_CYC;
    localparam int MAX_B = (CMD_WAIT_CYC > EN_HIGH_CYC) ? CMD_WAIT_CYC : EN_HIGH_CYC;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int TW    = $clog2(MAX_C + 1);

    localparam logic [TW-1:0] PWR_LAST = TW'(PWRUP_CYC - 1);
    localparam logic [TW-1:0] CMD_WAIT = TW'(CMD_WAIT_CYC);
    localparam logic [TW-1:0] CLR_WAIT = TW'(CLR_WAIT_CYC);

    top_state_t    state;
    top_state_t    launch_st;
    logic          launch;
    logic [TW-1:0] pwr_cnt;
    logic [8:0]    left_r;
    logic [8:0]    right_r;

    logic          tx_rs;
    logic [7:0]    tx_data;
    logic [TW-1:0] tx_wait;
    logic          tx_busy;
    logic          tx_done;

    assign lcd_rw = 1'b0;

    // Launch decode: the byte transmitter is started in the same edge that
    // the sequencer moves into the state for that byte, so consecutive bytes
    // follow with no idle cycle between them.
    always_comb begin
        launch    = 1'b0;
        launch_st = state;
        case (state)
            ST_PWRUP:    if (pwr_cnt == PWR_LAST) begin launch = 1'b1; launch_st = ST_INIT_FS;  end
            ST_INIT_FS:  if (tx_done)             begin launch = 1'b1; launch_st = ST_INIT_ON;  end
            ST_INIT_ON:  if (tx_done)             begin launch = 1'b1; launch_st = ST_INIT_CLR; end
            ST_INIT_CLR: if (tx_done)             begin launch = 1'b1; launch_st = ST_INIT_ENT; end
            ST_LOOKUP:   if (!tx_busy)            begin launch = 1'b1; launch_st = ST_ADDR_L;   end
            ST_ADDR_L:   if (tx_done)             begin launch = 1'b1; launch_st = ST_CHAR_L;   end
            ST_CHAR_L:   if (tx_done)             begin launch = 1'b1; launch_st = ST_ADDR_R;   end
            ST_ADDR_R:   if (tx_done)             begin launch = 1'b1; launch_st = ST_CHAR_R;   end
            default: ;
        endcase

        // Byte content for the state being launched into
        tx_rs   = 1'b0;
        tx_data = FUNC_SET_8B2L;
        tx_wait = CMD_WAIT;
        case (launch_st)
            ST_INIT_ON:  tx_data = DISP_ON;
            ST_INIT_CLR: begin tx_data = CLEAR; tx_wait = CLR_WAIT; end
            ST_INIT_ENT: tx_data = ENTRY_INC;
            ST_ADDR_L:   tx_data = LEFT_ADDR;
            ST_CHAR_L:   begin tx_rs = 1'b1; tx_data = char_byte(left_r); end
            ST_ADDR_R:   tx_data = RIGHT_ADDR;
            ST_CHAR_R:   begin tx_rs = 1'b1; tx_data = char_byte(right_r); end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_PWRUP;
            pwr_cnt   <= '0;
            rom_idx   <= 6'd0;
            left_r    <= 9'd0;
            right_r   <= 9'd0;
            init_done <= 1'b0;
            req_ready <= 1'b0;
        end else begin
            if (launch) state <= launch_st;
            case (state)
                // Power-up delay counts up from the cleared value to PWRUP_CYC-1.
                ST_PWRUP: begin
                    if (pwr_cnt != PWR_LAST) pwr_cnt <= pwr_cnt + 1'b1;
                end
                ST_INIT_ENT: begin
                    if (tx_done) begin
                        state     <= ST_IDLE;
                        init_done <= 1'b1;
                        req_ready <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        state     <= ST_LOOKUP;
                        rom_idx   <= req_idx;
                        req_ready <= 1'b0;
                    end
                end
                // map_rom answered combinationally on rom_idx; capture once so
                // later ROM changes cannot disturb the bytes in flight.
                ST_LOOKUP: begin
                    left_r  <= rom_left;
                    right_r <= rom_right;
                end
                ST_CHAR_R: begin
                    if (tx_done) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    lcd_byte_tx #(
        .TW          (TW),
        .EN_HIGH_CYC (EN_HIGH_CYC)
    ) u_tx (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (launch),
        .rs       (tx_rs),
        .data     (tx_data),
        .wait_cyc (tx_wait),
        .busy     (tx_busy),
        .done     (tx_done),
        .lcd_rs   (lcd_rs),
        .lcd_en   (lcd_en),
        .lcd_data (lcd_data)
    );

endmodule

// File: tb/tb_lcd_note_writer.sv
// tb_lcd_note_writer
//   Directed bench for lcd_note_writer with short timing parameters.
//   A bus monitor checks every LCD byte (rs, data, en high time, low gap)
//   against an expected queue filled by the stimulus.
module tb_lcd_note_writer;

    localparam int EN_HIGH  = 2;
    localparam int CMD_WAIT = 4;
    localparam int CLR_WAIT = 8;
    localparam int PWRUP    = 10;
    localparam int PERIOD   = 10;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [5:0] req_idx = 6'd0;
    logic       req_ready;
    logic [5:0] rom_idx;
    logic [8:0] rom_left = 9'd0;
    logic [8:0] rom_right = 9'd0;
    logic       init_done;
    logic       lcd_rs;
    logic       lcd_rw;
    logic       lcd_en;
    logic [7:0] lcd_data;

    int checks = 0;
    int failures = 0;

    // Expected byte: {gap[3:0], rs, data[7:0]}; gap = en-low samples
    // before the pulse, 0 = not checked.
    logic [12:0] exp_q[$];
    logic [12:0] head;
    logic        prev_en = 1'b0;
    int          low_cnt = 0;
    int          high_cnt = 0;
    time         fall_time = 0;

    lcd_note_writer #(
        .EN_HIGH_CYC  (EN_HIGH),
        .CMD_WAIT_CYC (CMD_WAIT),
        .CLR_WAIT_CYC (CLR_WAIT),
        .PWRUP_CYC    (PWRUP),
        .LEFT_ADDR    (8'h80),
        .RIGHT_ADDR   (8'h81)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_idx   (req_idx),
        .req_ready (req_ready),
        .rom_idx   (rom_idx),
        .rom_left  (rom_left),
        .rom_right (rom_right),
        .init_done (init_done),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_en    (lcd_en),
        .lcd_data  (lcd_data)
    );

    // ---------------- clock ----------------
    always #(PERIOD / 2) clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- LCD bus monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_en  = 1'b0;
            low_cnt  = 0;
            high_cnt = 0;
        end else begin
            check("lcd_rw_low", lcd_rw, 0);
            if (lcd_en && !prev_en) begin
                check("byte_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    head = exp_q[0];
                    if (head[12:9] != 4'd0) check("en_low_gap", low_cnt, head[12:9]);
                end
                high_cnt = 1;
            end else if (lcd_en) begin
                high_cnt++;
            end else if (prev_en) begin
                fall_time = $time;
                check("en_high_len", high_cnt, EN_HIGH);
                if (exp_q.size() != 0) begin
                    head = exp_q.pop_front();
                    check("byte_rs", lcd_rs, head[8]);
                    check("byte_data", lcd_data, head[7:0]);
                end
                low_cnt = 1;
            end else begin
                low_cnt++;
            end
            prev_en = lcd_en;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_init();
        exp_q.push_back({4'(PWRUP),        1'b0, 8'h38});
        exp_q.push_back({4'(CMD_WAIT + 1), 1'b0, 8'h0C});
        exp_q.push_back({4'(CMD_WAIT + 1), 1'b0, 8'h01});
        exp_q.push_back({4'(CLR_WAIT + 1), 1'b0, 8'h06});
    endtask

    task automatic push_seq(input logic [7:0] l, input logic [7:0] r);
        exp_q.push_back({4'd0,             1'b0, 8'h80});
        exp_q.push_back({4'(CMD_WAIT + 1), 1'b1, l});
        exp_q.push_back({4'(CMD_WAIT + 1), 1'b0, 8'h81});
        exp_q.push_back({4'(CMD_WAIT + 1), 1'b1, r});
    endtask

    task automatic wait_ready(input int budget, output int n);
        n = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            n++;
            if (req_ready) break;
        end
        check("ready_within_budget", req_ready, 1);
    endtask

    task automatic wait_init(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (init_done) break;
        end
        check("init_done_rise", init_done, 1);
        check("init_ready", req_ready, 1);
        check("init_done_after_wait", 32'($time - fall_time), CMD_WAIT * PERIOD);
        check("init_bytes_all_seen", exp_q.size(), 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n;
        logic found;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_lcd_en", lcd_en, 0);
        check("rst_lcd_rs", lcd_rs, 0);
        check("rst_lcd_data", lcd_data, 0);
        check("rst_rom_idx", rom_idx, 0);
        check("rst_init_done", init_done, 0);
        check("rst_req_ready", req_ready, 0);

        // 1: power-up init
        push_init();
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("pwrup_ready_low", req_ready, 0);
        check("pwrup_en_low", lcd_en, 0);
        wait_init(200);

        // 2: basic request
        @(negedge clk);
        rom_left = 9'h141; rom_right = 9'h123; req_idx = 6'd5; req_valid = 1'b1;
        push_seq(8'h41, 8'h23);
        @(negedge clk);                       // T+1
        req_valid = 1'b0;
        check("t2_rom_idx", rom_idx, 5);
        check("t2_ready_low", req_ready, 0);
        @(negedge clk);                       // T+2: SETUP of left address
        check("t2_setup_en", lcd_en, 0);
        check("t2_setup_data", lcd_data, 8'h80);
        @(negedge clk);                       // T+3: first enable high
        check("t2_first_rise", lcd_en, 1);
        wait_ready(100, n);
        check("t2_ready_latency", n, 27);
        check("t2_hold_data", lcd_data, 8'h23);
        check("t2_hold_rs", lcd_rs, 1);
        check("t2_queue_empty", exp_q.size(), 0);

        // 3: blank right cell
        rom_right = 9'h023; req_idx = 6'd7; req_valid = 1'b1;
        push_seq(8'h41, 8'h20);
        @(negedge clk);
        req_valid = 1'b0;
        check("t3_rom_idx", rom_idx, 7);
        wait_ready(100, n);
        check("t3_queue_empty", exp_q.size(), 0);

        // 4: request held during a sequence is not taken early
        rom_left = 9'h14C; rom_right = 9'h152; req_idx = 6'd3; req_valid = 1'b1;
        push_seq(8'h4C, 8'h52);
        @(negedge clk);
        req_idx = 6'd9;
        check("t4_first_idx", rom_idx, 3);
        repeat (10) @(negedge clk);
        check("t4_mid_idx", rom_idx, 3);
        check("t4_mid_ready", req_ready, 0);
        wait_ready(100, n);
        push_seq(8'h4C, 8'h52);
        @(negedge clk);
        req_valid = 1'b0;
        check("t4_second_idx", rom_idx, 9);
        check("t4_second_ready", req_ready, 0);
        wait_ready(100, n);
        check("t4_queue_empty", exp_q.size(), 0);

        // 5: ROM words change after capture
        rom_left = 9'h131; rom_right = 9'h132; req_idx = 6'd12; req_valid = 1'b1;
        push_seq(8'h31, 8'h32);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rom_left = 9'h15A; rom_right = 9'h000;
        wait_ready(100, n);
        check("t5_queue_empty", exp_q.size(), 0);

        // 6: reset in the middle of the left character pulse
        rom_left = 9'h145; rom_right = 9'h146; req_idx = 6'd20; req_valid = 1'b1;
        push_seq(8'h45, 8'h46);
        @(negedge clk);
        req_valid = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (lcd_en && lcd_rs) begin
                found = 1'b1;
                break;
            end
        end
        check("t6_char_pulse_seen", found, 1);
        #1 rst_n = 1'b0;
        #1;
        check("t6_rst_en", lcd_en, 0);
        check("t6_rst_rs", lcd_rs, 0);
        check("t6_rst_data", lcd_data, 0);
        check("t6_rst_idx", rom_idx, 0);
        check("t6_rst_init", init_done, 0);
        check("t6_rst_ready", req_ready, 0);
        exp_q.delete();
        push_init();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_init(200);
        check("t6_idx_after_init", rom_idx, 0);

        repeat (5) @(negedge clk);
        check("final_queue_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
